// File: rtl/booth_div_pkg.sv
// booth_div_pkg: shared types and constants for the sequential signed divider.
// Macro BOOTH_DIV_RADIX4_EN selects radix-4 iteration (2 quotient bits per step).
package booth_div_pkg;
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_e;
    localparam int W_DEF = 8;
    localparam int STEPS_R2 = W_DEF;
    localparam int STEPS_R4 = W_DEF / 2;
    localparam logic [W_DEF-1:0] Q_MAX = 8'h7F;
    localparam logic [W_DEF-1:0] Q_MIN = 8'h80;
`ifdef BOOTH_DIV_RADIX4_EN
    localparam int DIV_QB = 2;
`else
    localparam int DIV_QB = 1;
`endif
endpackage

// File: rtl/div_step.sv
// div_step: combinational restoring-division step cell.
// Ports: top_i = upper W+QB bits of the partial remainder after the left shift,
//        d_i = |divisor|, d3_i = 3*|divisor| (radix-4 only),
//        rem_o = new upper remainder half, q_o = quotient bit(s) of this step.
// Macro BOOTH_DIV_RADIX4_EN: radix-4 three-way compare, else radix-2 single compare.
module div_step
    import booth_div_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W+DIV_QB-1:0] top_i,
    input  logic [W-1:0]        d_i,
`ifdef BOOTH_DIV_RADIX4_EN
    input  logic [W+1:0]        d3_i,
`endif
    output logic [W-1:0]        rem_o,
    output logic [DIV_QB-1:0]   q_o
);
`ifdef BOOTH_DIV_RADIX4_EN
    logic [W+1:0] d1, d2;
    logic [W-1:0] sub;
    always_comb begin
        d1 = {2'b00, d_i};
        d2 = {1'b0, d_i, 1'b0};
        q_o = top_i >= d3_i ? 2'd3 : top_i >= d2 ? 2'd2 : top_i >= d1 ? 2'd1 : 2'd0;
        sub = q_o == 2'd3 ? d3_i[W-1:0] : q_o == 2'd2 ? d2[W-1:0] : q_o == 2'd1 ? d_i : '0;
        // true difference is < |divisor|, so modulo-2^W subtraction is exact
        rem_o = top_i[W-1:0] - sub;
    end
`else
    always_comb begin
        q_o = top_i >= {1'b0, d_i};
        rem_o = q_o[0] ? top_i[W-1:0] - d_i : top_i[W-1:0];
    end
`endif
endmodule

// File: rtl/booth_divider_seq.sv
// booth_divider_seq: sequential signed 2W/W divider, restoring shift-subtract.
// Ports: in_valid/in_ready accept dividend (2W) and divisor (W);
//        out_valid/out_ready return quot, rem (W each), dz and ovf flags.
// Macro BOOTH_DIV_RADIX4_EN: W/2 iteration cycles instead of W; same results.
module booth_divider_seq
    import booth_div_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quot,
    output logic [W-1:0]   rem,
    output logic           dz,
    output logic           ovf
);
`ifdef BOOTH_DIV_RADIX4_EN
    localparam int STEPS = W / 2;
`else
    localparam int STEPS = W;
`endif
    localparam int CW = $clog2(STEPS);
    state_e         state_q;
    logic [2*W-1:0] dvd_q, pr_q, dvd_mag;
    logic [W-1:0]   dvs_q, d_q, dvs_mag, quot_q, rem_q, qmag, rmag, step_rem;
    logic [CW-1:0]  cnt_q;
    logic           qs_q, rs_q, dz_f_q, ov_f_q, dz_q, ovf_q, post_ovf, sat;
    logic [DIV_QB-1:0] step_q;
`ifdef BOOTH_DIV_RADIX4_EN
    logic [W+1:0]   d3_q;
`endif
    always_comb begin
        dvd_mag = dvd_q[2*W-1] ? -dvd_q : dvd_q;
        dvs_mag = dvs_q[W-1] ? -dvs_q : dvs_q;
        qmag = pr_q[W-1:0];
        rmag = pr_q[2*W-1:W];
        // magnitude 2^(W-1) fits only as a negative quotient
        post_ovf = qmag[W-1] & ~(qs_q & ~|qmag[W-2:0]);
        sat = ov_f_q | post_ovf;
    end
    div_step #(.W(W)) u_step (
        .top_i (pr_q[2*W-1:W-DIV_QB]),
        .d_i   (d_q),
`ifdef BOOTH_DIV_RADIX4_EN
        .d3_i  (d3_q),
`endif
        .rem_o (step_rem),
        .q_o   (step_q)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q <= '0;
            dvs_q <= '0;
            pr_q <= '0;
            d_q <= '0;
`ifdef BOOTH_DIV_RADIX4_EN
            d3_q <= '0;
`endif
            cnt_q <= '0;
            qs_q <= 1'b0;
            rs_q <= 1'b0;
            dz_f_q <= 1'b0;
            ov_f_q <= 1'b0;
            quot_q <= '0;
            rem_q <= '0;
            dz_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    dvd_q <= dividend;
                    dvs_q <= divisor;
                    dz_f_q <= 1'b0;
                    ov_f_q <= 1'b0;
                    state_q <= PREP;
                end
                PREP: begin
                    qs_q <= dvd_q[2*W-1] ^ dvs_q[W-1];
                    rs_q <= dvd_q[2*W-1];
                    pr_q <= dvd_mag;
                    d_q <= dvs_mag;
`ifdef BOOTH_DIV_RADIX4_EN
                    d3_q <= {2'b00, dvs_mag} + {1'b0, dvs_mag, 1'b0};
`endif
                    cnt_q <= '0;
                    if (dvs_q == '0) begin
                        dz_f_q <= 1'b1;
                        state_q <= FIX;
                    end else if (dvd_mag[2*W-1:W] >= dvs_mag) begin
                        ov_f_q <= 1'b1;
                        state_q <= FIX;
                    end else begin
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    pr_q <= {step_rem, pr_q[W-DIV_QB-1:0], step_q};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(STEPS - 1)) state_q <= FIX;
                end
                FIX: begin
                    dz_q <= dz_f_q;
                    ovf_q <= ~dz_f_q & sat;
                    quot_q <= dz_f_q ? '0 : sat ? {qs_q, {(W-1){~qs_q}}} : qs_q ? -qmag : qmag;
                    rem_q <= dz_f_q ? dvd_q[W-1:0] : sat ? '0 : rs_q ? -rmag : rmag;
                    state_q <= DONE;
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign quot = quot_q;
    assign rem = rem_q;
    assign dz = dz_q;
    assign ovf = ovf_q;
endmodule
